// File: rtl/led_pwm_pkg.sv
// Shared constants and field layout for the PIO-driven LED controller.
// Each LED takes one byte of the PIO word: {mode[1:0], level[5:0]}.
package led_pwm_pkg;

    localparam int FIELD_W   = 8;
    localparam int LEVEL_W   = 6;
    localparam int NUM_LEDS  = 4;
    localparam int MS_CNT_W  = 14;
    localparam int PWM_CNT_W = 6;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;

    typedef struct packed {
        logic [1:0]         mode;
        logic [LEVEL_W-1:0] level;
    } led_field_t;

    // Bit of ms_cnt whose value is the blink phase: half-period 2^(6+sel) ms.
    function automatic logic [3:0] blink_bit(input logic [LEVEL_W-1:0] level);
        return 4'd6 + {1'b0, level[2:0]};
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED's combinational on/off decision from its config byte and the shared counters.
// Lamp test overrides every mode.
module led_pwm_channel
    import led_pwm_pkg::*;
(
    input  logic [FIELD_W-1:0]   field,
    input  logic [PWM_CNT_W-1:0] pwm_cnt,
    input  logic [MS_CNT_W-1:0]  ms_cnt,
    input  logic                 lamp,
    output logic                 on
);

    led_field_t cfg;
    assign cfg = led_field_t'(field);

    always_comb begin
        on = 1'b0;
        case (cfg.mode)
            MODE_OFF:   on = 1'b0;
            MODE_ON:    on = 1'b1;
            MODE_BLINK: on = ms_cnt[blink_bit(cfg.level)];
            // Level 63 still leaves one dark tick; full brightness is MODE_ON.
            MODE_PWM:   on = (pwm_cnt < cfg.level);
            default:    on = 1'b0;
        endcase
        if (lamp) begin
            on = 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Drives the board LEDs from the PIO word with off/on/blink/PWM per LED.
// Configuration is adopted only at a PWM period boundary so outputs never glitch.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int   PRESCALE       = 100,
    parameter int   MS_DIV         = 100000,
    parameter logic LED_ACTIVE_LOW = 1'b0
) (
    input  logic                  FPGA_CLKIN_100M,
    input  logic                  FPGA_RESETn,
    input  logic [31:0]           po_in,
    input  logic                  lamp_test,
    output logic [NUM_LEDS-1:0]   led_o,
    output logic [31:0]           cfg_active
);

    localparam int PRE_W = $clog2(PRESCALE);
    localparam int MS_W  = $clog2(MS_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(MS_DIV - 1);
    localparam logic [NUM_LEDS-1:0] LED_OFF_LEVEL = {NUM_LEDS{LED_ACTIVE_LOW}};

    logic [31:0]           po_q;
    logic [PRE_W-1:0]      pre_cnt;
    logic [PWM_CNT_W-1:0]  pwm_cnt;
    logic [MS_W-1:0]       ms_pre;
    logic [MS_CNT_W-1:0]   ms_cnt;
    logic                  lamp_meta;
    logic                  lamp_sync;
    logic                  pwm_tick;
    logic                  period_end;
    logic [NUM_LEDS-1:0]   led_on;

    assign pwm_tick   = (pre_cnt == PRE_MAX);
    assign period_end = pwm_tick && (pwm_cnt == {PWM_CNT_W{1'b1}});

    always_ff @(posedge FPGA_CLKIN_100M or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            po_q       <= '0;
            cfg_active <= '0;
        end else begin
            po_q <= po_in;
            if (period_end) begin
                cfg_active <= po_q;
            end
        end
    end

    always_ff @(posedge FPGA_CLKIN_100M or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= pwm_tick ? '0 : pre_cnt + 1'b1;
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Blink time base runs independently of the PWM period.
    always_ff @(posedge FPGA_CLKIN_100M or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            ms_pre <= '0;
            ms_cnt <= '0;
        end else if (ms_pre == MS_MAX) begin
            ms_pre <= '0;
            ms_cnt <= ms_cnt + 1'b1;
        end else begin
            ms_pre <= ms_pre + 1'b1;
        end
    end

    always_ff @(posedge FPGA_CLKIN_100M or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            lamp_meta <= 1'b0;
            lamp_sync <= 1'b0;
        end else begin
            lamp_meta <= lamp_test;
            lamp_sync <= lamp_meta;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            led_pwm_channel u_chan (
                .field   (cfg_active[gi*FIELD_W +: FIELD_W]),
                .pwm_cnt (pwm_cnt),
                .ms_cnt  (ms_cnt),
                .lamp    (lamp_sync),
                .on      (led_on[gi])
            );
        end
    endgenerate

    always_ff @(posedge FPGA_CLKIN_100M or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            led_o <= LED_OFF_LEVEL;
        end else begin
            led_o <= led_on ^ LED_OFF_LEVEL;
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: directed scenarios plus randomized configs checked
// against a cycle-indexed arithmetic model of the LED behaviour.
module tb_led_pwm_ctrl;

    localparam int P      = 2;
    localparam int M      = 4;
    localparam int PERIOD = 64 * P;
    localparam int HIST   = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] po_in = '0;
    logic        lamp_test = 1'b0;
    logic [3:0]  led_o;
    logic [3:0]  led_o_al;
    logic [31:0] cfg_active;
    logic [31:0] cfg_active_al;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    logic [31:0] po_hist   [0:HIST-1];
    logic        lamp_hist [0:HIST-1];

    led_pwm_ctrl #(.PRESCALE(P), .MS_DIV(M), .LED_ACTIVE_LOW(1'b0)) dut (
        .FPGA_CLKIN_100M (clk),
        .FPGA_RESETn     (rst_n),
        .po_in           (po_in),
        .lamp_test       (lamp_test),
        .led_o           (led_o),
        .cfg_active      (cfg_active)
    );

    led_pwm_ctrl #(.PRESCALE(P), .MS_DIV(M), .LED_ACTIVE_LOW(1'b1)) dut_al (
        .FPGA_CLKIN_100M (clk),
        .FPGA_RESETn     (rst_n),
        .po_in           (po_in),
        .lamp_test       (lamp_test),
        .led_o           (led_o_al),
        .cfg_active      (cfg_active_al)
    );

    always #5 clk = ~clk;

    // edge_n = number of clock edges seen with reset released; inputs logged per edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n <= 0;
        end else if (edge_n < HIST - 1) begin
            edge_n                <= edge_n + 1;
            po_hist[edge_n + 1]   <= po_in;
            lamp_hist[edge_n + 1] <= lamp_test;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (state after edge n) ----------------
    function automatic int model_pwm(int n);
        return (n / P) % 64;
    endfunction

    function automatic int model_ms(int n);
        return (n / M) % 16384;
    endfunction

    function automatic logic [31:0] model_cfg(int n);
        int m;
        m = (n / PERIOD) * PERIOD;
        if (m == 0) return 32'h0;
        return po_hist[m - 1];
    endfunction

    function automatic logic [3:0] model_led(int n);
        logic [31:0] cfg;
        logic [3:0]  res;
        logic        lamp;
        int          pc, ms, mode, level, half;
        res = 4'h0;
        if (n <= 0) return res;
        cfg  = model_cfg(n - 1);
        pc   = model_pwm(n - 1);
        ms   = model_ms(n - 1);
        lamp = (n - 1 >= 2) ? lamp_hist[n - 2] : 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode  = int'(cfg[8*i+6 +: 2]);
            level = int'(cfg[8*i +: 6]);
            half  = 64 << (level % 8);
            case (mode)
                1:       res[i] = 1'b1;
                2:       res[i] = ((ms / half) % 2) == 1;
                3:       res[i] = pc < level;
                default: res[i] = 1'b0;
            endcase
        end
        if (lamp) res = 4'hF;
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step_to(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] po);
        @(negedge clk);
        rst_n     = 1'b0;
        po_in     = po;
        lamp_test = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        po_in = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if (led_o !== 4'h0) $display("FAIL reset_led: got %h want 0", led_o); else n_pass++;
        n_checks++;
        if (cfg_active !== 32'h0) $display("FAIL reset_cfg: got %h want 0", cfg_active); else n_pass++;
        n_checks++;
        if (led_o_al !== 4'hF) $display("FAIL reset_led_active_low: got %h want f", led_o_al); else n_pass++;
        n_checks++;
        if (dut.pwm_cnt !== 6'd0 || dut.ms_cnt !== 14'd0)
            $display("FAIL reset_counters: pwm %0d ms %0d want 0 0", dut.pwm_cnt, dut.ms_cnt);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_adoption;
        do_reset(32'h0);
        step_to(4);
        po_in = 32'h0000_0040;
        step_to(127);
        n_checks++;
        if (cfg_active !== 32'h0) $display("FAIL adopt_early: cfg %h at edge 127 want 0", cfg_active); else n_pass++;
        step_to(128);
        n_checks++;
        if (cfg_active !== 32'h40) $display("FAIL adopt_edge128: cfg %h want 00000040", cfg_active); else n_pass++;
        n_checks++;
        if (led_o[0] !== 1'b0) $display("FAIL adopt_led_128: led0 %b want 0", led_o[0]); else n_pass++;
        step_to(129);
        n_checks++;
        if (led_o !== 4'h1) $display("FAIL adopt_led_129: led %h want 1", led_o); else n_pass++;
        n_checks++;
        if (led_o_al !== 4'hE) $display("FAIL adopt_led_al_129: led %h want e", led_o_al); else n_pass++;
        $display("test_adoption done");
    endtask

    task automatic count_led(input int idx, input int cycles, output int high);
        high = 0;
        for (int k = 0; k < cycles; k++) begin
            step_to(edge_n + 1);
            if (led_o[idx] === 1'b1) high++;
        end
    endtask

    task automatic test_pwm_duty;
        int high;
        do_reset(32'h0000_D000);
        step_to(256);
        count_led(1, PERIOD, high);
        n_checks++;
        if (high !== 32) $display("FAIL pwm_level16: high %0d want 32", high); else n_pass++;
        po_in = 32'h0000_C000;
        step_to(edge_n + 2 * PERIOD + 4);
        count_led(1, PERIOD, high);
        n_checks++;
        if (high !== 0) $display("FAIL pwm_level0: high %0d want 0", high); else n_pass++;
        po_in = 32'h0000_FF00;
        step_to(edge_n + 2 * PERIOD + 4);
        count_led(1, PERIOD, high);
        n_checks++;
        if (high !== PERIOD - 2) $display("FAIL pwm_level63: high %0d want %0d", high, PERIOD - 2); else n_pass++;
        $display("test_pwm_duty done");
    endtask

    task automatic test_blink;
        int   toggles[$];
        logic prev;
        do_reset(32'h0080_0000);
        step_to(1);
        n_checks++;
        if (led_o[2] !== 1'b0) $display("FAIL blink_start: led2 %b want 0", led_o[2]); else n_pass++;
        prev = led_o[2];
        while (edge_n < 900) begin
            step_to(edge_n + 1);
            if (led_o[2] !== prev) toggles.push_back(edge_n);
            prev = led_o[2];
        end
        n_checks++;
        if (toggles.size() !== 3) $display("FAIL blink_count: toggles %0d want 3", toggles.size());
        else n_pass++;
        for (int k = 0; k < toggles.size() && k < 3; k++) begin
            n_checks++;
            if (toggles[k] !== 257 + 256 * k)
                $display("FAIL blink_edge%0d: toggle at %0d want %0d", k, toggles[k], 257 + 256 * k);
            else n_pass++;
        end
        $display("test_blink done");
    endtask

    task automatic test_lamp;
        do_reset(32'h0);
        step_to(10);
        lamp_test = 1'b1;
        step_to(12);
        n_checks++;
        if (led_o !== 4'h0) $display("FAIL lamp_on_early: led %h want 0", led_o); else n_pass++;
        step_to(13);
        n_checks++;
        if (led_o !== 4'hF) $display("FAIL lamp_on: led %h want f", led_o); else n_pass++;
        n_checks++;
        if (led_o_al !== 4'h0) $display("FAIL lamp_on_al: led %h want 0", led_o_al); else n_pass++;
        n_checks++;
        if (cfg_active !== 32'h0) $display("FAIL lamp_cfg: cfg %h want 0", cfg_active); else n_pass++;
        step_to(20);
        lamp_test = 1'b0;
        step_to(22);
        n_checks++;
        if (led_o !== 4'hF) $display("FAIL lamp_off_early: led %h want f", led_o); else n_pass++;
        step_to(23);
        n_checks++;
        if (led_o !== 4'h0) $display("FAIL lamp_off: led %h want 0", led_o); else n_pass++;
        $display("test_lamp done");
    endtask

    task automatic test_reset_mid;
        do_reset(32'h0000_0040);
        step_to(301);
        n_checks++;
        if (led_o !== 4'h1) $display("FAIL mid_pre_led: led %h want 1", led_o); else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut.pre_cnt !== '0 || dut.pwm_cnt !== 6'd0 || dut.ms_pre !== '0 || dut.ms_cnt !== 14'd0)
            $display("FAIL mid_counters: pre %0d pwm %0d mspre %0d ms %0d want 0",
                     dut.pre_cnt, dut.pwm_cnt, dut.ms_pre, dut.ms_cnt);
        else n_pass++;
        n_checks++;
        if (cfg_active !== 32'h0 || led_o !== 4'h0)
            $display("FAIL mid_cfg_led: cfg %h led %h want 0 0", cfg_active, led_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step_to(2);
        n_checks++;
        if (dut.pwm_cnt !== 6'd1) $display("FAIL mid_first_tick: pwm %0d want 1", dut.pwm_cnt); else n_pass++;
        step_to(127);
        n_checks++;
        if (cfg_active !== 32'h0) $display("FAIL mid_pending: cfg %h want 0", cfg_active); else n_pass++;
        step_to(128);
        n_checks++;
        if (cfg_active !== 32'h40) $display("FAIL mid_readopt: cfg %h want 00000040", cfg_active); else n_pass++;
        $display("test_reset_mid done");
    endtask

    task automatic test_boundary;
        do_reset(32'h0000_0040);
        step_to(127);
        po_in = 32'h4000_0000;
        step_to(128);
        n_checks++;
        if (cfg_active !== 32'h0000_0040) $display("FAIL boundary_old: cfg %h want 00000040", cfg_active); else n_pass++;
        step_to(255);
        n_checks++;
        if (cfg_active !== 32'h0000_0040) $display("FAIL boundary_hold: cfg %h want 00000040", cfg_active); else n_pass++;
        step_to(256);
        n_checks++;
        if (cfg_active !== 32'h4000_0000) $display("FAIL boundary_new: cfg %h want 40000000", cfg_active); else n_pass++;
        $display("test_boundary done");
    endtask

    task automatic test_random;
        logic [3:0] exp_led;
        do_reset($urandom);
        step_to(1);
        while (edge_n < 3000) begin
            exp_led = model_led(edge_n);
            n_checks++;
            if (led_o !== exp_led) begin
                $display("FAIL random_led: edge %0d led %h want %h", edge_n, led_o, exp_led);
                break;
            end
            n_pass++;
            n_checks++;
            if (led_o_al !== ~exp_led) begin
                $display("FAIL random_led_al: edge %0d led %h want %h", edge_n, led_o_al, ~exp_led);
                break;
            end
            n_pass++;
            n_checks++;
            if (cfg_active !== model_cfg(edge_n)) begin
                $display("FAIL random_cfg: edge %0d cfg %h want %h", edge_n, cfg_active, model_cfg(edge_n));
                break;
            end
            n_pass++;
            if ($urandom_range(99) == 0) po_in = $urandom;
            if ($urandom_range(199) == 0) lamp_test = ~lamp_test;
            step_to(edge_n + 1);
        end
        $display("test_random done at edge %0d", edge_n);
    endtask

    initial begin
        test_reset;
        test_adoption;
        test_pwm_duty;
        test_blink;
        test_lamp;
        test_reset_mid;
        test_boundary;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
